sram_byte_bridge: RTL and testbench

Requester-side controller for the 512x8 single-port byte SRAM macro (active-low CEN/GWEN, registered Q). Accepts 32-bit word requests over a valid/ready bus port and serialises them into byte accesses on the macro pins. Sits between the SoC bus fabric and one byte-wide SRAM instance, giving the fabric a 128-word x 32-bit memory with byte strobes.

---
 rtl/sram_byte_bridge.sv | 157 +++++++++++++++
 tb/tb_sram_byte_bridge.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_byte_bridge.sv
// Word-to-byte bridge in front of a 512x8 single-port SRAM macro (CEN/GWEN active-low, registered Q).
// Optional one-word read buffer enabled by defining SRAM_BRIDGE_WORD_CACHE_EN.
module sram_byte_bridge (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        sram_cen,
    output logic        sram_gwen,
    output logic [3:0]  sram_wmask,
    output logic [8:0]  sram_a,
    output logic [7:0]  sram_d,
    input  logic [7:0]  sram_q
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t      state;
    logic [6:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  pend;
    logic [2:0]  rd_cnt;
    logic [23:0] rbuf;
    logic [1:0]  first_req;
    logic [1:0]  first_pend;

`ifdef SRAM_BRIDGE_WORD_CACHE_EN
    logic        c_valid;
    logic [6:0]  c_tag;
    logic [31:0] c_data;
    logic        c_match;
    assign c_match = c_valid && (c_tag == req_addr);
`endif

    function automatic logic [1:0] first_bit(input logic [3:0] m);
        first_bit = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) first_bit = 2'(i);
    endfunction

    assign first_req  = first_bit(req_wstrb);
    assign first_pend = first_bit(pend);
    assign sram_wmask = 4'b0000;

    // NOTE: every output is a flop, so nothing on req_* reaches sram_*/rsp_* combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_a    <= 9'd0;
            sram_d    <= 8'd0;
            addr_q    <= 7'd0;
            wdata_q   <= 32'd0;
            pend      <= 4'd0;
            rd_cnt    <= 3'd0;
            rbuf      <= 24'd0;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
            c_valid   <= 1'b0;
            c_tag     <= 7'd0;
            c_data    <= 32'd0;
`endif
        end else begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rd_cnt    <= 3'd0;
                        req_ready <= 1'b0;
                        if (req_we) begin
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
                            for (int i = 0; i < 4; i++)
                                if (c_match && req_wstrb[i])
                                    c_data[8*i +: 8] <= req_wdata[8*i +: 8];
`endif
                            if (req_wstrb == 4'd0) begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_rdata <= 32'd0;
                            end else begin
                                sram_cen  <= 1'b0;
                                sram_gwen <= 1'b0;
                                sram_a    <= {req_addr, first_req};
                                sram_d    <= req_wdata[{first_req, 3'b000} +: 8];
                                pend      <= req_wstrb & ~(4'b0001 << first_req);
                                state     <= WRITE;
                            end
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
                        end else if (c_match) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= c_data;
`endif
                        end else begin
                            sram_cen <= 1'b0;
                            sram_a   <= {req_addr, 2'd0};
                            state    <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (pend != 4'd0) begin
                        sram_cen  <= 1'b0;
                        sram_gwen <= 1'b0;
                        sram_a    <= {addr_q, first_pend};
                        sram_d    <= wdata_q[{first_pend, 3'b000} +: 8];
                        pend      <= pend & ~(4'b0001 << first_pend);
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end
                end
                READ: begin
                    // Issue runs one byte ahead of capture because Q lags the issue by a cycle.
                    rd_cnt <= rd_cnt + 3'd1;
                    if (rd_cnt < 3'd3) begin
                        sram_cen <= 1'b0;
                        sram_a   <= {addr_q, rd_cnt[1:0] + 2'd1};
                    end
                    if (rd_cnt >= 3'd1 && rd_cnt <= 3'd3)
                        rbuf <= {sram_q, rbuf[23:8]};
                    if (rd_cnt == 3'd4) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= {sram_q, rbuf};
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
                        c_valid   <= 1'b1;
                        c_tag     <= addr_q;
                        c_data    <= {sram_q, rbuf};
`endif
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_rdata <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Self-checking bench for sram_byte_bridge: vector table, reset corner cases and random traffic
// against a word-level memory model; includes a behavioural 512x8 macro with registered Q.
module tb_sram_byte_bridge;

`ifdef SRAM_BRIDGE_WORD_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int RD_HIT_LAT = CACHE ? 0 : 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [6:0]  req_addr = 7'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        sram_cen;
    logic        sram_gwen;
    logic [3:0]  sram_wmask;
    logic [8:0]  sram_a;
    logic [7:0]  sram_d;
    logic [7:0]  sram_q = 8'd0;

    int n_cmp = 0;
    int n_fail = 0;

    sram_byte_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wmask(sram_wmask),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // Macro model and pin monitor: {gwen, a, d (writes only)} per active cycle.
    logic [7:0]  mem [512];
    logic [17:0] mon_q [$];

    always @(posedge clk) begin
        if (sram_cen === 1'b0) begin
            if (sram_gwen === 1'b0) mem[sram_a] <= sram_d;
            else                    sram_q <= mem[sram_a];
            mon_q.push_back({sram_gwen, sram_a, (sram_gwen ? 8'h00 : sram_d)});
        end
    end

    // Word-level reference model
    logic [31:0] m_mem [128];
    bit          m_cv;
    logic [6:0]  m_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {req_ready, rsp_valid, rsp_rdata, sram_cen, sram_gwen, sram_a, sram_d, sram_wmask},
              {1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 9'd0, 8'd0, 4'd0});
    endtask

    task automatic do_req(input bit we, input logic [6:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
        logic [17:0] exp_q [$];
        logic [17:0] act_e, exp_e;
        logic [31:0] exp_rd;
        int          exp_lat, t;
        bit          hit;

        hit = CACHE && m_cv && (m_tag == addr);
        exp_lat = 0;
        if (we) begin
            for (int k = 0; k < 4; k++)
                if (wstrb[k]) begin
                    exp_q.push_back({1'b0, addr, 2'(k), wdata[8*k +: 8]});
                    exp_lat++;
                end
            exp_rd = 32'd0;
        end else begin
            if (!hit) begin
                for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, addr, 2'(k), 8'h00});
                exp_lat = 5;
            end
            exp_rd = m_mem[addr];
        end

        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 0, 1);

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        mon_q.delete();
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = 7'($urandom);
        check("ready_low", req_ready, 1'b0);

        lat = -1;
        rdata = 32'hx;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin
                lat = k;
                rdata = rsp_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        check("rsp_latency", lat, exp_lat);
        check("rsp_rdata", rdata, exp_rd);

        act_e = 18'd0; exp_e = 18'd0;
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
            if (mon_q[i] !== exp_q[i] && act_e == 18'd0 && exp_e == 18'd0) begin
                act_e = mon_q[i];
                exp_e = exp_q[i];
            end
        check("macro_count", mon_q.size(), exp_q.size());
        check("macro_seq", act_e, exp_e);

        @(posedge clk); #1;
        check("rsp_pulse_ready", {rsp_valid, req_ready}, 2'b01);

        if (we) begin
            for (int k = 0; k < 4; k++)
                if (wstrb[k]) m_mem[addr][8*k +: 8] = wdata[8*k +: 8];
        end else begin
            m_cv = 1'b1;
            m_tag = addr;
        end
    endtask

    typedef struct {
        bit          we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          saw_rsp, saw_cen;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        for (int i = 0; i < 128; i++) m_mem[i] = 32'd0;
        m_cv = 1'b0;
        m_tag = 7'd0;

        vecs[0]  = '{1'b1, 7'h05, 32'hDEADBEEF, 4'hF, 32'h0, 4};
        vecs[1]  = '{1'b0, 7'h05, 32'h0,        4'h0, 32'hDEADBEEF, 5};
        vecs[2]  = '{1'b1, 7'h05, 32'h11223344, 4'hA, 32'h0, 2};
        vecs[3]  = '{1'b0, 7'h05, 32'h0,        4'h0, 32'h11AD33EF, RD_HIT_LAT};
        vecs[4]  = '{1'b1, 7'h05, 32'h99999999, 4'h0, 32'h0, 0};
        vecs[5]  = '{1'b0, 7'h05, 32'h0,        4'h0, 32'h11AD33EF, RD_HIT_LAT};
        vecs[6]  = '{1'b1, 7'h05, 32'h00000077, 4'h1, 32'h0, 1};
        vecs[7]  = '{1'b0, 7'h05, 32'h0,        4'h0, 32'h11AD3377, RD_HIT_LAT};
        vecs[8]  = '{1'b1, 7'h7F, 32'hA5A55A5A, 4'hF, 32'h0, 4};
        vecs[9]  = '{1'b0, 7'h7F, 32'h0,        4'h0, 32'hA5A55A5A, 5};
        vecs[10] = '{1'b0, 7'h05, 32'h0,        4'h0, 32'h11AD3377, 5};
        vecs[11] = '{1'b1, 7'h00, 32'hCAFEF00D, 4'h8, 32'h0, 1};
        vecs[12] = '{1'b0, 7'h00, 32'h0,        4'h0, 32'hCA000000, 5};

        // Reset held for three cycles
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset_values");
        end
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        // Reset sampled at E2 of a read aborts it without a response
        m_cv = 1'b0;
        do_req(1'b0, 7'h05, 32'h0, 4'h0, rd, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h05;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("mid_read_reset");
        @(negedge clk);
        rst_n = 1'b1;
        m_cv = 1'b0;
        saw_rsp = 1'b0; saw_cen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
            if (!sram_cen) saw_cen = 1'b1;
        end
        check("abort_no_rsp_no_cen", {saw_rsp, saw_cen, req_ready}, 3'b001);
        do_req(1'b0, 7'h05, 32'h0, 4'h0, rd, lat);
        check("after_abort_read", rd, 32'h11AD3377);

        // Random traffic, addresses clustered so repeat reads happen
        for (int i = 0; i < 150; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 5));
            do_req(1'($urandom), a, $urandom, 4'($urandom), rd, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
